// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Brief    : N-channel common-data-bus arbiter with a registered CDB broadcast
// Revision : 1.0
// ============================================================================
module cdb_arbiter #(
    parameter int N_CH    = 4,
    parameter int W_DATA  = 32,
    parameter int W_TAG   = 6,
    parameter int RR_MODE = 1,
    localparam int W_SRC  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          ch_req,
    input  logic [N_CH*W_TAG-1:0]    ch_tag,
    input  logic [N_CH*W_DATA-1:0]   ch_data,
    input  logic [N_CH-1:0]          ch_branch,
    input  logic [N_CH-1:0]          ch_taken,
    output logic [N_CH-1:0]          ch_done,
    input  logic                     flush,
    output logic                     cdb_valid,
    output logic [W_TAG-1:0]         cdb_tag,
    output logic [W_DATA-1:0]        cdb_data,
    output logic                     cdb_branch,
    output logic                     cdb_taken,
    output logic [W_SRC-1:0]         cdb_src
);

    localparam logic [W_SRC:0] N_CH_W = (W_SRC+1)'(N_CH);

    logic [W_SRC-1:0]  ptr_q, ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [W_TAG-1:0]  cdb_tag_q, cdb_tag_d;
    logic [W_DATA-1:0] cdb_data_q, cdb_data_d;
    logic              cdb_branch_q, cdb_branch_d;
    logic              cdb_taken_q, cdb_taken_d;
    logic [W_SRC-1:0]  cdb_src_q, cdb_src_d;

    logic [W_SRC-1:0]  start;
    logic [N_CH-1:0]   req_rot;
    logic [W_SRC:0]    off;
    logic [W_SRC:0]    sum;
    logic [W_SRC:0]    nxt;
    logic              grant_any;
    logic              grant_ok;
    logic [W_SRC-1:0]  grant_idx;

    // Rotate requests so bit 0 is the search start, pick the lowest set bit,
    // then map the offset back to an absolute channel index modulo N_CH.
    always_comb begin
        start     = (RR_MODE != 0) ? ptr_q : '0;
        req_rot   = N_CH'({ch_req, ch_req} >> start);
        grant_any = 1'b0;
        off       = '0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                grant_any = 1'b1;
                off       = (W_SRC+1)'(j);
            end
        end
        sum = {1'b0, start} + off;
        if (sum >= N_CH_W) begin
            sum = sum - N_CH_W;
        end
        grant_idx = sum[W_SRC-1:0];
        grant_ok  = grant_any & ~flush & ~reset;
    end

    always_comb begin
        ch_done = '0;
        for (int k = 0; k < N_CH; k++) begin
            ch_done[k] = grant_ok && (grant_idx == W_SRC'(k));
        end
    end

    always_comb begin
        cdb_valid_d  = grant_ok;
        cdb_tag_d    = cdb_tag_q;
        cdb_data_d   = cdb_data_q;
        cdb_branch_d = cdb_branch_q;
        cdb_taken_d  = cdb_taken_q;
        cdb_src_d    = cdb_src_q;
        ptr_d        = ptr_q;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_done[k]) begin
                cdb_tag_d    = ch_tag[k*W_TAG +: W_TAG];
                cdb_data_d   = ch_data[k*W_DATA +: W_DATA];
                cdb_branch_d = ch_branch[k];
                cdb_taken_d  = ch_taken[k] & ch_branch[k];
                cdb_src_d    = W_SRC'(k);
            end
        end
        // Explicit wrap keeps non-power-of-two channel counts in range.
        nxt = {1'b0, grant_idx} + 1'b1;
        if (nxt >= N_CH_W) begin
            nxt = '0;
        end
        if (grant_ok && (RR_MODE != 0)) begin
            ptr_d = nxt[W_SRC-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q        <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_data_q   <= '0;
            cdb_branch_q <= 1'b0;
            cdb_taken_q  <= 1'b0;
            cdb_src_q    <= '0;
        end else begin
            ptr_q        <= ptr_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_data_q   <= cdb_data_d;
            cdb_branch_q <= cdb_branch_d;
            cdb_taken_q  <= cdb_taken_d;
            cdb_src_q    <= cdb_src_d;
        end
    end

    assign cdb_valid  = cdb_valid_q;
    assign cdb_tag    = cdb_tag_q;
    assign cdb_data   = cdb_data_q;
    assign cdb_branch = cdb_branch_q;
    assign cdb_taken  = cdb_taken_q;
    assign cdb_src    = cdb_src_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Scoreboard bench for cdb_arbiter (RR x4, fixed-priority x4, RR x3)
// Revision : 1.0
// ============================================================================
module tb_cdb_arbiter;

    typedef struct packed {
        logic        v;
        logic [5:0]  tag;
        logic [31:0] data;
        logic        br;
        logic        tk;
        logic [1:0]  src;
    } cdb_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req, br, tk;
    logic [23:0]  tag;
    logic [127:0] data;
    logic         flush;
    logic [3:0]   done;
    logic         valid, obr, otk;
    logic [5:0]   otag;
    logic [31:0]  odata;
    logic [1:0]   osrc;

    logic [3:0]   done_f;
    logic         valid_f, obr_f, otk_f;
    logic [5:0]   otag_f;
    logic [31:0]  odata_f;
    logic [1:0]   osrc_f;

    logic [2:0]   req3, br3, tk3;
    logic [17:0]  tag3;
    logic [95:0]  data3;
    logic         flush3;
    logic [2:0]   done3;
    logic         valid3, obr3, otk3;
    logic [5:0]   otag3;
    logic [31:0]  odata3;
    logic [1:0]   osrc3;

    cdb_t sb[$];
    cdb_t sb3[$];
    cdb_t last, last3, got, exp_e, fexp;
    int   nvec  = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(.N_CH(4), .W_DATA(32), .W_TAG(6), .RR_MODE(1)) dut (
        .clk(clk), .reset(reset), .ch_req(req), .ch_tag(tag), .ch_data(data),
        .ch_branch(br), .ch_taken(tk), .ch_done(done), .flush(flush),
        .cdb_valid(valid), .cdb_tag(otag), .cdb_data(odata),
        .cdb_branch(obr), .cdb_taken(otk), .cdb_src(osrc)
    );

    cdb_arbiter #(.N_CH(4), .W_DATA(32), .W_TAG(6), .RR_MODE(0)) dut_fp (
        .clk(clk), .reset(reset), .ch_req(req), .ch_tag(tag), .ch_data(data),
        .ch_branch(br), .ch_taken(tk), .ch_done(done_f), .flush(flush),
        .cdb_valid(valid_f), .cdb_tag(otag_f), .cdb_data(odata_f),
        .cdb_branch(obr_f), .cdb_taken(otk_f), .cdb_src(osrc_f)
    );

    cdb_arbiter #(.N_CH(3), .W_DATA(32), .W_TAG(6), .RR_MODE(1)) dut3 (
        .clk(clk), .reset(reset), .ch_req(req3), .ch_tag(tag3), .ch_data(data3),
        .ch_branch(br3), .ch_taken(tk3), .ch_done(done3), .flush(flush3),
        .cdb_valid(valid3), .cdb_tag(otag3), .cdb_data(odata3),
        .cdb_branch(obr3), .cdb_taken(otk3), .cdb_src(osrc3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_payload(input int seed);
        for (int k = 0; k < 4; k++) begin
            tag[k*6 +: 6]   = 6'((seed * 7 + k * 13) & 63);
            data[k*32 +: 32] = 32'h5A00_0000 ^ 32'(seed << 8) ^ 32'(k);
        end
        for (int k = 0; k < 3; k++) begin
            tag3[k*6 +: 6]   = 6'((seed * 5 + k * 11) & 63);
            data3[k*32 +: 32] = 32'h3300_0000 ^ 32'(seed << 4) ^ 32'(k);
        end
    endtask

    // Expected broadcast for the next edge; k < 0 means no grant (hold payload).
    task automatic push_exp(input int k);
        cdb_t e;
        if (k < 0) begin
            e   = last;
            e.v = 1'b0;
        end else begin
            e.v    = 1'b1;
            e.tag  = tag[k*6 +: 6];
            e.data = data[k*32 +: 32];
            e.br   = br[k];
            e.tk   = br[k] & tk[k];
            e.src  = 2'(k);
            last   = e;
        end
        sb.push_back(e);
    endtask

    task automatic push_exp3(input int k);
        cdb_t e;
        if (k < 0) begin
            e   = last3;
            e.v = 1'b0;
        end else begin
            e.v    = 1'b1;
            e.tag  = tag3[k*6 +: 6];
            e.data = data3[k*32 +: 32];
            e.br   = br3[k];
            e.tk   = br3[k] & tk3[k];
            e.src  = 2'(k);
            last3  = e;
        end
        sb3.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; flush3 = 1'b0;
        req = 4'hF; br = 4'h0; tk = 4'h0;
        req3 = 3'b111; br3 = 3'b000; tk3 = 3'b000;
        set_payload(0);
        last = '0; last3 = '0;
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if (done !== 4'h0 || done_f !== 4'h0 || done3 !== 3'b000) begin
            nfail++;
            $display("FAIL reset_done: got %b/%b/%b want 0", done, done_f, done3);
        end
        got = {valid, otag, odata, obr, otk, osrc};
        nvec++;
        if (got !== cdb_t'('0)) begin
            nfail++; $display("FAIL reset_cdb: got %h want 0", got);
        end
        got = {valid3, otag3, odata3, obr3, otk3, osrc3};
        nvec++;
        if (got !== cdb_t'('0)) begin
            nfail++; $display("FAIL reset_cdb3: got %h want 0", got);
        end
        reset = 1'b0;
        req3  = 3'b000;
        #1;
        nvec++;
        if (done !== 4'b0001) begin
            nfail++; $display("FAIL first_grant: got %b want 0001", done);
        end
        push_exp(0);
        tick();
        got = {valid, otag, odata, obr, otk, osrc}; exp_e = sb.pop_front(); nvec++;
        if (got !== exp_e) begin nfail++; $display("FAIL first_cdb: got %h want %h", got, exp_e); end
        req = 4'h0;
        #1;
        push_exp(-1);
        tick();
        got = {valid, otag, odata, obr, otk, osrc}; exp_e = sb.pop_front(); nvec++;
        if (got !== exp_e) begin nfail++; $display("FAIL idle_hold: got %h want %h", got, exp_e); end
    endtask

    task automatic test_single();
        req = 4'b0100;
        tag[12 +: 6]  = 6'h2A;
        data[64 +: 32] = 32'hDEADBEEF;
        #1;
        nvec++;
        if (done !== 4'b0100 || done_f !== 4'b0100) begin
            nfail++; $display("FAIL single_done: got %b/%b want 0100", done, done_f);
        end
        push_exp(2);
        tick();
        got = {valid, otag, odata, obr, otk, osrc}; exp_e = sb.pop_front(); nvec++;
        if (got !== exp_e) begin nfail++; $display("FAIL single_cdb: got %h want %h", got, exp_e); end
        req = 4'h0;
        #1;
        nvec++;
        if (done !== 4'h0) begin nfail++; $display("FAIL single_drop: got %b want 0000", done); end
        push_exp(-1);
        tick();
        got = {valid, otag, odata, obr, otk, osrc}; exp_e = sb.pop_front(); nvec++;
        if (got !== exp_e) begin nfail++; $display("FAIL single_hold: got %h want %h", got, exp_e); end
    endtask

    task automatic test_back_to_back();
        int ek;
        // Pointer sits at 3 after the single-request test; get valid high first.
        req = 4'hF;
        #1;
        push_exp(3);
        tick();
        got = {valid, otag, odata, obr, otk, osrc}; exp_e = sb.pop_front(); nvec++;
        if (got !== exp_e) begin nfail++; $display("FAIL pre_reset_cdb: got %h want %h", got, exp_e); end
        reset = 1'b1;
        #1;
        got = {valid, otag, odata, obr, otk, osrc}; nvec++;
        if (got !== cdb_t'('0) || done !== 4'h0) begin
            nfail++; $display("FAIL async_reset: got %h done %b want 0", got, done);
        end
        sb.delete(); sb3.delete();
        last = '0; last3 = '0;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_payload(i + 10);
            #1;
            ek = i % 4;
            nvec++;
            if (done !== 4'(1 << ek)) begin
                nfail++; $display("FAIL rr_done[%0d]: got %b want %b", i, done, 4'(1 << ek));
            end
            nvec++;
            if (done_f !== 4'b0001) begin
                nfail++; $display("FAIL fp_done[%0d]: got %b want 0001", i, done_f);
            end
            push_exp(ek);
            fexp = {1'b1, tag[5:0], data[31:0], br[0], br[0] & tk[0], 2'd0};
            tick();
            got = {valid, otag, odata, obr, otk, osrc}; exp_e = sb.pop_front(); nvec++;
            if (got !== exp_e) begin nfail++; $display("FAIL rr_cdb[%0d]: got %h want %h", i, got, exp_e); end
            got = {valid_f, otag_f, odata_f, obr_f, otk_f, osrc_f}; nvec++;
            if (got !== fexp) begin nfail++; $display("FAIL fp_cdb[%0d]: got %h want %h", i, got, fexp); end
        end
        req = 4'hE;
        #1;
        nvec++;
        if (done_f !== 4'b0010 || done !== 4'b0100) begin
            nfail++; $display("FAIL drop_ch0: got rr %b fp %b want 0100/0010", done, done_f);
        end
        push_exp(2);
        tick();
        got = {valid, otag, odata, obr, otk, osrc}; exp_e = sb.pop_front(); nvec++;
        if (got !== exp_e) begin nfail++; $display("FAIL drop_cdb: got %h want %h", got, exp_e); end
        req = 4'h0;
        #1;
        push_exp(-1);
        tick();
        got = {valid, otag, odata, obr, otk, osrc}; exp_e = sb.pop_front(); nvec++;
        if (got !== exp_e) begin nfail++; $display("FAIL drop_idle: got %h want %h", got, exp_e); end
    endtask

    task automatic test_wrap3();
        int ek;
        req3 = 3'b010;
        set_payload(20);
        #1;
        nvec++;
        if (done3 !== 3'b010) begin nfail++; $display("FAIL wrap3_pre: got %b want 010", done3); end
        push_exp3(1);
        tick();
        got = {valid3, otag3, odata3, obr3, otk3, osrc3}; exp_e = sb3.pop_front(); nvec++;
        if (got !== exp_e) begin nfail++; $display("FAIL wrap3_pre_cdb: got %h want %h", got, exp_e); end
        req3 = 3'b101;
        for (int i = 0; i < 4; i++) begin
            set_payload(21 + i);
            #1;
            ek = (i % 2 == 0) ? 2 : 0;
            nvec++;
            if (done3 !== 3'(1 << ek)) begin
                nfail++; $display("FAIL wrap3_done[%0d]: got %b want %b", i, done3, 3'(1 << ek));
            end
            push_exp3(ek);
            tick();
            got = {valid3, otag3, odata3, obr3, otk3, osrc3}; exp_e = sb3.pop_front(); nvec++;
            if (got !== exp_e) begin nfail++; $display("FAIL wrap3_cdb[%0d]: got %h want %h", i, got, exp_e); end
        end
        req3 = 3'b000;
        #1;
        push_exp3(-1);
        tick();
        got = {valid3, otag3, odata3, obr3, otk3, osrc3}; exp_e = sb3.pop_front(); nvec++;
        if (got !== exp_e) begin nfail++; $display("FAIL wrap3_idle: got %h want %h", got, exp_e); end
    endtask

    task automatic test_flush();
        req = 4'b0010; br = 4'b0010; tk = 4'b0010;
        set_payload(30);
        flush = 1'b1;
        #1;
        nvec++;
        if (done !== 4'h0 || done_f !== 4'h0) begin
            nfail++; $display("FAIL flush_done: got %b/%b want 0000", done, done_f);
        end
        push_exp(-1);
        tick();
        got = {valid, otag, odata, obr, otk, osrc}; exp_e = sb.pop_front(); nvec++;
        if (got !== exp_e) begin nfail++; $display("FAIL flush_cdb: got %h want %h", got, exp_e); end
        flush = 1'b0;
        #1;
        nvec++;
        if (done !== 4'b0010) begin nfail++; $display("FAIL post_flush_done: got %b want 0010", done); end
        push_exp(1);
        tick();
        got = {valid, otag, odata, obr, otk, osrc}; exp_e = sb.pop_front(); nvec++;
        if (got !== exp_e) begin nfail++; $display("FAIL branch_taken: got %h want %h", got, exp_e); end
        br = 4'b0000;
        set_payload(31);
        #1;
        push_exp(1);
        tick();
        got = {valid, otag, odata, obr, otk, osrc}; exp_e = sb.pop_front(); nvec++;
        if (got !== exp_e) begin nfail++; $display("FAIL taken_nobranch: got %h want %h", got, exp_e); end
        req = 4'h0; tk = 4'h0;
        #1;
        push_exp(-1);
        tick();
        got = {valid, otag, odata, obr, otk, osrc}; exp_e = sb.pop_front(); nvec++;
        if (got !== exp_e) begin nfail++; $display("FAIL flush_idle: got %h want %h", got, exp_e); end
    endtask

    task automatic test_random();
        int mptr;
        int ek;
        int idx;
        int waits[4];
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        sb.delete(); last = '0;
        mptr = 0;
        for (int k = 0; k < 4; k++) waits[k] = 0;
        for (int i = 0; i < 60; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (!req[k] && ($urandom_range(0, 1) == 1)) begin
                    req[k]          = 1'b1;
                    tag[k*6 +: 6]   = 6'($urandom);
                    data[k*32 +: 32] = $urandom;
                    br[k]           = 1'($urandom_range(0, 1));
                    tk[k]           = 1'($urandom_range(0, 1));
                end
            end
            flush = ($urandom_range(0, 7) == 0);
            #1;
            ek = -1;
            if (!flush) begin
                for (int s = 0; s < 4; s++) begin
                    idx = (mptr + s) % 4;
                    if (ek < 0 && req[idx]) ek = idx;
                end
            end
            nvec++;
            if (done !== ((ek < 0) ? 4'h0 : 4'(1 << ek))) begin
                nfail++; $display("FAIL rand_done[%0d]: got %b want ch %0d", i, done, ek);
            end
            push_exp(ek);
            if (ek >= 0) begin
                nvec++;
                if (waits[ek] > 3) begin
                    nfail++; $display("FAIL rand_fair[%0d]: ch %0d waited %0d grants, limit 3", i, ek, waits[ek]);
                end
                waits[ek] = 0;
                for (int k = 0; k < 4; k++) if (k != ek && req[k]) waits[k]++;
                mptr = (ek + 1) % 4;
            end
            tick();
            got = {valid, otag, odata, obr, otk, osrc}; exp_e = sb.pop_front(); nvec++;
            if (got !== exp_e) begin nfail++; $display("FAIL rand_cdb[%0d]: got %h want %h", i, got, exp_e); end
            if (ek >= 0) req[ek] = 1'b0;
        end
        flush = 1'b0;
        req   = 4'h0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap3();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
# cdb_arbiter

Parametrised common-data-bus arbiter for the Tomasulo core. It takes result requests from N_CH issue units (int, ld/st, mult, div and any future units), grants one per cycle, and drives a registered CDB broadcast. The broadcast carries tag, data, valid, branch and taken to dispatch and every execution queue. It replaces the constant-zero CDB drivers in the cpu top and scales to any unit count and width.

## Interface
Parameters:
- N_CH, 4, number of requesting units (2..8)
- W_DATA, 32, result data width
- W_TAG, 6, physical tag width
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (channel 0 highest)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- ch_req  input  N_CH  per-channel result request
- ch_tag  input  N_CH*W_TAG  per-channel rd tag; channel k at [k*W_TAG +: W_TAG]
- ch_data  input  N_CH*W_DATA  per-channel result; channel k at [k*W_DATA +: W_DATA]
- ch_branch  input  N_CH  result is a branch resolution
- ch_taken  input  N_CH  branch outcome, meaningful only with ch_branch
- ch_done  output  N_CH  one-hot grant, combinational, same cycle as accepted request
- flush  input  1  branch-mispredict flush; blocks grants this cycle
- cdb_valid  output  1  broadcast valid
- cdb_tag  output  W_TAG  broadcast tag
- cdb_data  output  W_DATA  broadcast data
- cdb_branch  output  1  broadcast is a branch resolution
- cdb_taken  output  1  branch taken
- cdb_src  output  clog2(N_CH)  index of the granting channel, for debug

## Operation
- State:
  - rotating priority pointer ptr, clog2(N_CH) bits
  - output registers cdb_*
- Grant is computed combinationally each cycle:
  - RR_MODE=1: first requesting channel at or after ptr, searching upward modulo N_CH.
  - RR_MODE=0: lowest-index requesting channel.
- ch_done[k]=1 only for the granted channel. All ch_done are 0 when no channel requests or flush=1.
- On a grant to channel k at a clock edge:
  - cdb_* load channel k's tag, data, branch and taken; cdb_valid=1; cdb_src=k.
  - ptr loads (k+1) mod N_CH, wrapping correctly for non-power-of-two N_CH. In RR_MODE=0 ptr is unused and stays 0.
- No grant (no requests or flush): cdb_valid loads 0. cdb_tag, cdb_data, cdb_branch, cdb_taken and cdb_src hold their previous values. ptr is unchanged.
- cdb_taken is registered as ch_taken & ch_branch of the granted channel.
- Requester rule: hold ch_req and payload stable until ch_done is seen high, and drop or replace them in the cycle after ch_done.
- Ungranted requests are neither lost nor latched: they are re-evaluated every cycle.
- With RR_MODE=1, a channel waits at most N_CH-1 grants before its own grant.
- Reset: ptr=0, cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_branch=0, cdb_taken=0, cdb_src=0. ch_done is 0 while reset is high.

## Timing
- Request to ch_done: 0 cycles, combinational.
- Request to cdb_valid: 1 cycle. Data is registered at the edge where ch_done was high.
- Throughput: one broadcast per cycle. Back-to-back grants give cdb_valid high on consecutive cycles.
- Reset asserted mid-stream: outputs go to reset values immediately, without waiting for a clock edge. The first grant after reset release starts from channel 0.
- flush high on the same edge as a pending request: no grant is issued, and cdb_valid is 0 on the next cycle. The requester's state persists across the flush; cancelling requests is the requester's job.

## Test plan
- Reset with all ch_req=1 -> ch_done=0 and every cdb_* output 0. After release, the first grant goes to channel 0.
- Single request, ch_req=4'b0100, tag 6'h2A, data 32'hDEADBEEF -> ch_done=4'b0100 the same cycle. Next cycle: cdb_valid=1, cdb_tag=6'h2A, cdb_data=32'hDEADBEEF, cdb_src=2.
- RR_MODE=1, all four channels requesting continuously -> grant order 0,1,2,3,0,1. cdb_valid stays high on every cycle.
- RR_MODE=0 under the same stimulus -> channel 0 is always granted. When channel 0 drops its request, channel 1 is granted.
- N_CH=3, requests on channels 2 and 0 only -> grants alternate 2,0,2,0, with the pointer wrapping 2→0 without error.
- Channel 1 presents ch_branch=1, ch_taken=1 while flush pulses for one cycle:
  - flush cycle: no ch_done; the following cycle cdb_valid=0.
  - next cycle: grant to channel 1, then cdb_branch=1 and cdb_taken=1.
  - separate case: ch_branch=0, ch_taken=1 -> cdb_taken=0.
